// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit: redirect-source
// encoding and default reset/exception vectors.
package pc_pkg;

  typedef enum logic [2:0] {
    NXT_EXC,
    NXT_RET,
    NXT_BR,
    NXT_JMP,
    NXT_SEQ
  } nxt_sel_e;

  localparam logic [15:0] DEFAULT_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEFAULT_EXC_VEC   = 16'h0008;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// All state changes on the falling edge, in step with the pipeline registers.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
  // ptr_q is the next free slot, so the top lives one below it (mod depth).
  assign top   = stack_q[ptr_q - PTR_W'(1)];

  // NOTE: every variable gets a default before the if-chain so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      cnt_d = full ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array is deliberately unreset; validity is tracked by cnt_q alone.
  always_ff @(negedge clk) begin
    if (push && !clear) stack_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects
// (exception > return > branch > jump > sequential) and a return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEFAULT_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(DEFAULT_EXC_VEC),
  parameter int unsigned     INC       = 1,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            exc,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] ret_target,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_seq,
  output logic [PC_W-1:0] epc_out,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ret_miss
);

  logic [PC_W-1:0] pc_q, pc_d, epc_q, epc_d, ras_top;
  logic            ret_miss_q, ret_miss_d;
  logic            ras_push, ras_pop;
  nxt_sel_e        sel;

  assign pc_out   = pc_q;
  assign pc_seq   = pc_q + PC_W'(INC);
  assign epc_out  = epc_q;
  assign ret_miss = ret_miss_q;

  always_comb begin
    if (exc)               sel = NXT_EXC;
    else if (ret)          sel = NXT_RET;
    else if (branch_taken) sel = NXT_BR;
    else if (jump)         sel = NXT_JMP;
    else                   sel = NXT_SEQ;
  end

  // Stalls gate every side effect except the exception path.
  assign ras_push = ce && (sel == NXT_JMP) && call;
  assign ras_pop  = ce && (sel == NXT_RET) && !ras_empty;

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    ret_miss_d = 1'b0;
    if (sel == NXT_EXC) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
    end else if (ce) begin
      unique case (sel)
        NXT_RET: begin
          pc_d       = ras_empty ? ret_target : ras_top;
          ret_miss_d = ras_empty;
        end
        NXT_BR:  pc_d = branch_target;
        NXT_JMP: pc_d = jump_target;
        default: pc_d = pc_seq;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      ret_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      ret_miss_q <= ret_miss_d;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (exc),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule
